// File: rtl/operand_stack.sv
// operand_stack: operand stack feeding the ALU's TOS/NOS inputs and taking
// its results back as writeback or push data. It accepts one 3-bit command
// per cycle, and the outputs reflect that command one cycle later.
// Storage is a circular array. The write pointer is the low bits of count,
// so a full stack points back at slot 0.
// stack0/stack1 are shadow registers that are written together with the array.
// Optional feature macro: OPSTACK_PEAK_EN adds peak_o, the high-water mark of count.
module operand_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [2:0]       cmd_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic [WIDTH-1:0] wb0_i,
  input  logic [WIDTH-1:0] wb1_i,
  output logic [WIDTH-1:0] stack0_o,
  output logic [WIDTH-1:0] stack1_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o,
`ifdef OPSTACK_PEAK_EN
  output logic [CW-1:0]    peak_o,
`endif
  output logic             err_o
);

  typedef enum logic [2:0] {
    C_NOP   = 3'b000,
    C_PUSH  = 3'b001,
    C_POP   = 3'b010,
    C_BINOP = 3'b011,
    C_WB2   = 3'b100,
    C_DUP   = 3'b101,
    C_SWAP  = 3'b110,
    C_CLEAR = 3'b111
  } cmd_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;
  logic             err_q, err_d;

  // Two write ports: WB2 and SWAP update both the TOS and NOS slots.
  logic             we0, we1;
  logic [AW-1:0]    wa0, wa1;
  logic [WIDTH-1:0] wd0, wd1;

  logic [AW-1:0]    ptr, ptr_m1, ptr_m2, ptr_m3;
  logic             has1, has2, has3, room;
  logic [WIDTH-1:0] third;

  assign ptr    = cnt_q[AW-1:0];
  assign ptr_m1 = ptr - AW'(1);
  assign ptr_m2 = ptr - AW'(2);
  assign ptr_m3 = ptr - AW'(3);
  assign has1   = (cnt_q != '0);
  assign has2   = (cnt_q >= CW'(2));
  assign has3   = (cnt_q >= CW'(3));
  assign room   = (cnt_q != CW'(DEPTH));
  // Entry that becomes NOS after a net pop. It is zero if the stack is too shallow.
  assign third  = has3 ? mem_q[ptr_m3] : '0;

  // Next-state decode. An illegal command changes nothing except setting err.
  always_comb begin
    cnt_d = cnt_q;
    s0_d  = s0_q;
    s1_d  = s1_q;
    err_d = err_q;
    we0   = 1'b0;
    wa0   = ptr;
    wd0   = push_data_i;
    we1   = 1'b0;
    wa1   = ptr_m2;
    wd1   = wb1_i;
    case (cmd_e'(cmd_i))
      C_PUSH: begin
        if (room) begin
          we0   = 1'b1;
          s0_d  = push_data_i;
          s1_d  = s0_q;
          cnt_d = cnt_q + CW'(1);
        end else err_d = 1'b1;
      end
      C_POP: begin
        if (has1) begin
          s0_d  = s1_q;
          s1_d  = third;
          cnt_d = cnt_q - CW'(1);
        end else err_d = 1'b1;
      end
      C_BINOP: begin
        if (has2) begin
          we0   = 1'b1;
          wa0   = ptr_m2;
          wd0   = wb0_i;
          s0_d  = wb0_i;
          s1_d  = third;
          cnt_d = cnt_q - CW'(1);
        end else err_d = 1'b1;
      end
      C_WB2: begin
        if (has2) begin
          we0  = 1'b1;
          wa0  = ptr_m1;
          wd0  = wb0_i;
          we1  = 1'b1;
          s0_d = wb0_i;
          s1_d = wb1_i;
        end else err_d = 1'b1;
      end
      C_DUP: begin
        if (has1 && room) begin
          we0   = 1'b1;
          wd0   = s0_q;
          s1_d  = s0_q;
          cnt_d = cnt_q + CW'(1);
        end else err_d = 1'b1;
      end
      C_SWAP: begin
        if (has2) begin
          we0  = 1'b1;
          wa0  = ptr_m1;
          wd0  = s1_q;
          we1  = 1'b1;
          wd1  = s0_q;
          s0_d = s1_q;
          s1_d = s0_q;
        end else err_d = 1'b1;
      end
      C_CLEAR: begin
        cnt_d = '0;
        s0_d  = '0;
        s1_d  = '0;
        err_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Storage array. Its contents are don't-care after reset, so it has no reset.
  always_ff @(posedge clk_i) begin
    if (we0) mem_q[wa0] <= wd0;
    if (we1) mem_q[wa1] <= wd1;
  end

  // Architectural registers. The asynchronous reset aborts any in-flight command.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      s0_q  <= '0;
      s1_q  <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      err_q <= err_d;
    end
  end

`ifdef OPSTACK_PEAK_EN
  logic [CW-1:0] peak_q, peak_d;

  // High-water mark. It moves in the same cycle count does and is zeroed by CLEAR.
  always_comb begin
    peak_d = peak_q;
    if (cmd_e'(cmd_i) == C_CLEAR) peak_d = '0;
    else if (cnt_d > peak_q)      peak_d = cnt_d;
  end

  // Peak register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) peak_q <= '0;
    else         peak_q <= peak_d;
  end

  assign peak_o = peak_q;
`endif

  assign stack0_o = s0_q;
  assign stack1_o = s1_q;
  assign count_o  = cnt_q;
  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == CW'(DEPTH));
  assign err_o    = err_q;

endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
Hardware operand stack that supplies the ALU's stack0 (top of stack, TOS) and stack1 (next on stack, NOS) inputs. It also accepts the ALU's stack0_out and stack1_out results back as writeback or push data. It is the producer/consumer counterpart to the ALU's stack-operand interface and is driven each cycle by the decode stage with a 3-bit command.

Parameters:
WIDTH, 8, data width of each stack entry.
DEPTH, 8, number of entries; must be a power of two, at least 2.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
cmd  input  3  stack command (encoding below); sampled every rising edge.
push_data  input  WIDTH  value for PUSH.
wb0  input  WIDTH  ALU stack0_out result.
wb1  input  WIDTH  ALU stack1_out result.
stack0  output  WIDTH  registered TOS; 0 when count==0.
stack1  output  WIDTH  registered NOS; 0 when count<2.
count  output  $clog2(DEPTH)+1  current number of entries.
empty  output  1  count==0.
full  output  1  count==DEPTH.
err  output  1  sticky error flag; set on overflow or underflow.

Behaviour:
- Reset (asynchronous, active-high), effective immediately:
  - count=0, stack0=0, stack1=0, empty=1, full=0, err=0.
  - Storage contents are don't-care.
  - Reset during any command aborts it; no partial update.
- Command encoding; each command takes effect at the rising edge and outputs are valid the next cycle (1-cycle latency):
  - 000 NOP: no change.
  - 001 PUSH: requires count<DEPTH. push_data becomes TOS, old TOS becomes NOS, count+1.
  - 010 POP: requires count>=1. NOS becomes TOS, count-1.
  - 011 BINOP: requires count>=2. Pops two entries and pushes wb0; count-1. New TOS=wb0; new NOS = old third entry, or 0 if none.
  - 100 WB2: requires count>=2. TOS<=wb0, NOS<=wb1; count unchanged.
  - 101 DUP: requires 1<=count<DEPTH. Pushes a copy of TOS; count+1.
  - 110 SWAP: requires count>=2. Exchanges TOS and NOS.
  - 111 CLEAR: count<=0, err<=0.
- Illegal commands:
  - A command whose requirement fails is an overflow or underflow.
  - No state change except err<=1.
  - err stays set until reset or CLEAR.
- Storage:
  - Circular array indexed by a stack pointer; wrap-around is not allowed because count is bounded by full/empty.
  - stack0/stack1 are registers updated together with the array, never combinational reads of the array.
- Flags:
  - empty/full are derived from registered count. They are glitch-free and update in the same cycle as stack0/stack1.
- Arithmetic:
  - No arithmetic inside the block; wb0/wb1 are stored verbatim, with WIDTH-bit truncation done by the ALU.
  - count does not saturate because illegal commands are blocked.
- Boundary cases:
  - PUSH at full: err=1; TOS unchanged.
  - POP at empty: err=1.
  - BINOP with count==1: err=1; TOS is kept.
  - BINOP at count==2 gives count=1, stack1=0.
  - POP to count==1 gives stack1=0.
  - POP to count==0 gives stack0=0.
  - CLEAR while err=1 clears err.

Optional Feature:
OPSTACK_PEAK_EN
- Defined: adds output port peak ($clog2(DEPTH)+1 bits), the high-water mark of count.
  - Reset to 0 and cleared by CLEAR.
  - Updated the same cycle count exceeds it.
- Not defined: port and register are absent; all other behaviour is identical.

Test Plan:
1. Reset, then PUSH 34, PUSH 76 -> stack0=76, stack1=34, count=2. Then BINOP with wb0=110 -> stack0=110, stack1=0, count=1, err=0.
2. PUSH 30, 50, 70; SWAP -> stack0=50, stack1=70. POP -> stack0=70, stack1=30, count=2.
3. DEPTH=8: push 1..8 -> full=1, stack0=8. PUSH 9 -> err=1, stack0=8, count=8. CLEAR -> count=0, empty=1, err=0.
4. From empty: POP -> err=1, count=0, stack0=0. Then PUSH 5 still works -> stack0=5 with err still 1.
5. PUSH 21, PUSH 13; WB2 with wb0=8, wb1=0xE3 -> stack0=8, stack1=0xE3, count=2. DUP -> stack0=8, stack1=8, count=3.
6. Assert reset mid-sequence, between edges, with count=3 -> outputs are 0 and count=0 immediately, without waiting for a clock edge. With OPSTACK_PEAK_EN defined, peak=0 and rises to 3 after three PUSHes.
